pipe_hazard_ctrl: RTL

Hazard and stall controller for the five-stage RV32I pipeline (IF, ID, EX, MEM, WB). It takes decoded register and control fields from ID, branch resolution from EX and the data-memory handshake from MEM. From these it drives the pipeline-register enables, flushes and bubbles, plus registered forwarding selects for the EX-stage ALU operand muxes. It keeps its own shadow of the EX and MEM destination registers, a memory-wait state machine with timeout, and a saturating stall counter.

---
 rtl/pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall controller for the five-stage RV32I pipeline.
// Produces pipeline-register enables, flush and bubble controls, registered
// EX operand forwarding selects, a sticky memory-wait timeout flag and a
// saturating count of cycles in which the PC did not advance.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_we,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0]  FWD_RF     = 2'b00;
    localparam logic [1:0]  FWD_EXMEM  = 2'b01;
    localparam logic [1:0]  FWD_MEMWB  = 2'b10;
    localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT);

    typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} mem_state_t;

    mem_state_t  state;
    mem_state_t  state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;

    // Shadow copies of the destination fields of the instructions in EX and MEM
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        ex_ld;
    logic [4:0]  mem_rd;
    logic        mem_we;

    logic        freeze;
    logic        load_use;
    logic        kill_id;
    logic [1:0]  fwd_a_nxt;
    logic [1:0]  fwd_b_nxt;

    // The youngest in-flight producer wins; x0 is never a real producer.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] e_rd, input logic e_we,
                                           input logic [4:0] m_rd, input logic m_we);
        logic [1:0] sel;
        sel = FWD_RF;
        if (e_we && (e_rd != 5'd0) && (rs == e_rd)) begin
            sel = FWD_EXMEM;
        end else if (m_we && (m_rd != 5'd0) && (rs == m_rd)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    assign freeze    = mem_req & ~mem_ack;
    assign load_use  = id_valid & ex_ld & ex_we & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    // Branch flush and load-use stall both replace the ID instruction with a NOP in EX
    assign kill_id   = ex_branch_taken | load_use;
    assign fwd_a_nxt = fwd_sel(id_rs1, ex_rd, ex_we, mem_rd, mem_we);
    assign fwd_b_nxt = fwd_sel(id_rs2, ex_rd, ex_we, mem_rd, mem_we);

    // Memory-wait state, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if ((state_nxt == ST_WAIT) && (wait_cnt_nxt == WAIT_LIMIT)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Next memory-wait state; the counter holds the length of the current wait
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_RUN: begin
                if (freeze) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = 16'd1;
                end else begin
                    wait_cnt_nxt = 16'd0;
                end
            end
            ST_WAIT: begin
                if (freeze) begin
                    if (wait_cnt != 16'hFFFF) begin
                        wait_cnt_nxt = wait_cnt + 16'd1;
                    end
                end else begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = 16'd0;
                end
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = 16'd0;
            end
        endcase
    end

    // Pipeline controls by priority: reset, memory freeze, branch flush, load-use, advance
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b0;
        end else if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Shadow pipeline and forwarding selects advance whenever the pipe is not frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd  <= 5'd0;
            ex_we  <= 1'b0;
            ex_ld  <= 1'b0;
            mem_rd <= 5'd0;
            mem_we <= 1'b0;
            fwd_a  <= FWD_RF;
            fwd_b  <= FWD_RF;
        end else if (!freeze) begin
            mem_rd <= ex_rd;
            mem_we <= ex_we;
            if (kill_id) begin
                ex_rd <= 5'd0;
                ex_we <= 1'b0;
                ex_ld <= 1'b0;
                fwd_a <= FWD_RF;
                fwd_b <= FWD_RF;
            end else begin
                ex_rd <= id_rd;
                ex_we <= id_reg_we & id_valid;
                ex_ld <= id_is_load & id_valid;
                fwd_a <= fwd_a_nxt;
                fwd_b <= fwd_b_nxt;
            end
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
